// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked ALU with registered flags and a one-bit-per-cycle shifter
module alu_seq #(
  parameter int W  = 8,
  parameter int SW = $clog2(W)
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         InValid,
  output logic         InReady,
  input  logic [2:0]   Op,
  input  logic [W-1:0] InA,
  input  logic [W-1:0] InB,
  output logic         OutValid,
  input  logic         OutReady,
  output logic [W-1:0] Out,
  output logic         OutWrEn,
  output logic         Zero,
  output logic         Carry,
  output logic         Neg,
  output logic         Busy
);

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpLsl = 3'b001;
  localparam logic [2:0] OpXor = 3'b010;
  localparam logic [2:0] OpAnd = 3'b011;
  localparam logic [2:0] OpCmp = 3'b100;
  localparam logic [2:0] OpSet = 3'b101;
  localparam logic [2:0] OpLsr = 3'b110;
  localparam logic [2:0] OpSub = 3'b111;

  typedef enum logic {StIdle, StShift} stateT;

  stateT         state, stateNext;
  logic [SW-1:0] shiftCount, shiftCountNext;
  logic [W-1:0]  shiftReg, shiftRegNext;
  logic          shiftRight, shiftRightNext;

  logic          accept;
  logic          isShift;
  logic [SW-1:0] amount;
  logic [W:0]    sumExt;
  logic [W:0]    diffExt;
  logic [W-1:0]  stepSrc;
  logic          stepRight;
  logic [W-1:0]  stepRes;
  logic          stepOut;

  logic          load;
  logic [W-1:0]  loadOut;
  logic          loadWrEn;
  logic          loadCarry;
  logic          loadFlags;

  assign InReady = (state == StIdle) & (~OutValid | OutReady);
  assign Busy    = (state == StShift);
  assign accept  = InValid & InReady;
  assign isShift = (Op == OpLsl) | (Op == OpLsr);
  assign amount  = InB[SW-1:0];

  // Arithmetic and a single-bit shift step; the first step works on the
  // incoming operand so a shift by n finishes on the n-th edge.
  always_comb begin
    sumExt    = {1'b0, InA} + {1'b0, InB};
    diffExt   = {1'b0, InA} - {1'b0, InB};
    stepSrc   = (state == StIdle) ? InA : shiftReg;
    stepRight = (state == StIdle) ? (Op == OpLsr) : shiftRight;
    if (stepRight) begin
      stepRes = {1'b0, stepSrc[W-1:1]};
      stepOut = stepSrc[0];
    end else begin
      stepRes = {stepSrc[W-2:0], 1'b0};
      stepOut = stepSrc[W-1];
    end
  end

  // Next-state logic and selection of the result to load into the output stage.
  always_comb begin
    stateNext      = state;
    shiftCountNext = shiftCount;
    shiftRegNext   = shiftReg;
    shiftRightNext = shiftRight;
    load           = 1'b0;
    loadOut        = '0;
    loadWrEn       = 1'b1;
    loadCarry      = 1'b0;
    loadFlags      = 1'b1;
    case (state)
      StIdle: begin
        if (accept) begin
          if (isShift) begin
            if (amount == '0) begin
              load    = 1'b1;
              loadOut = InA;
            end else if (amount == SW'(1)) begin
              load      = 1'b1;
              loadOut   = stepRes;
              loadCarry = stepOut;
            end else begin
              stateNext      = StShift;
              shiftRegNext   = stepRes;
              shiftRightNext = stepRight;
              shiftCountNext = amount - SW'(1);
            end
          end else begin
            load = 1'b1;
            case (Op)
              OpAdd: begin
                loadOut   = sumExt[W-1:0];
                loadCarry = sumExt[W];
              end
              OpSub: begin
                loadOut   = diffExt[W-1:0];
                loadCarry = ~diffExt[W];
              end
              OpCmp: begin
                loadOut   = diffExt[W-1:0];
                loadCarry = ~diffExt[W];
                loadWrEn  = 1'b0;
              end
              OpXor: loadOut = InA ^ InB;
              OpAnd: loadOut = InA & InB;
              OpSet: begin
                loadOut   = InB;
                loadFlags = 1'b0;
              end
              default: load = 1'b0;
            endcase
          end
        end
      end
      StShift: begin
        shiftRegNext = stepRes;
        if (shiftCount == SW'(1)) begin
          stateNext      = StIdle;
          shiftCountNext = '0;
          load           = 1'b1;
          loadOut        = stepRes;
          loadCarry      = stepOut;
        end else begin
          shiftCountNext = shiftCount - SW'(1);
        end
      end
      default: stateNext = StIdle;
    endcase
  end

  // State, shifter and output/flag registers; a new result wins over a drain.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= StIdle;
      shiftCount <= '0;
      shiftReg   <= '0;
      shiftRight <= 1'b0;
      OutValid   <= 1'b0;
      Out        <= '0;
      OutWrEn    <= 1'b0;
      Zero       <= 1'b0;
      Carry      <= 1'b0;
      Neg        <= 1'b0;
    end else begin
      state      <= stateNext;
      shiftCount <= shiftCountNext;
      shiftReg   <= shiftRegNext;
      shiftRight <= shiftRightNext;
      if (load) begin
        OutValid <= 1'b1;
        Out      <= loadOut;
        OutWrEn  <= loadWrEn;
        if (loadFlags) begin
          Zero  <= (loadOut == '0);
          Neg   <= loadOut[W-1];
          Carry <= loadCarry;
        end
      end else if (OutReady) begin
        OutValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - randomized and directed checks of alu_seq against a behavioural model
module tb_alu_seq;

  localparam int W = 8;

  logic         clk;
  logic         Reset;
  logic         InValid;
  logic         InReady;
  logic [2:0]   Op;
  logic [W-1:0] InA;
  logic [W-1:0] InB;
  logic         OutValid;
  logic         OutReady;
  logic [W-1:0] Out;
  logic         OutWrEn;
  logic         Zero;
  logic         Carry;
  logic         Neg;
  logic         Busy;

  int checks = 0;
  int errors = 0;

  alu_seq #(.W(W)) dut (
    .Clk(clk), .Reset(Reset), .InValid(InValid), .InReady(InReady),
    .Op(Op), .InA(InA), .InB(InB),
    .OutValid(OutValid), .OutReady(OutReady), .Out(Out), .OutWrEn(OutWrEn),
    .Zero(Zero), .Carry(Carry), .Neg(Neg), .Busy(Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model state: cycles left until a pending result appears,
  // plus the visible output/flag values.
  int         mLeft = 0;
  bit         mOutValid = 0;
  logic [7:0] mOut = 8'h00;
  bit         mWr = 0;
  bit         mZ = 0;
  bit         mC = 0;
  bit         mN = 0;
  logic [7:0] pRes = 8'h00;
  bit         pC = 0;
  bit         mAcc = 0;
  bit         cmpEn = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic calc(input logic [2:0] op, input int a, input int b,
                      output logic [7:0] res, output bit c, output bit wr,
                      output bit fl, output int lat);
    int n;
    int t;
    n   = b % 8;
    wr  = 1;
    fl  = 1;
    lat = 1;
    c   = 0;
    t   = 0;
    case (op)
      3'd0: begin t = a + b; c = (t > 255); end
      3'd1: begin
        t = (a << n) & 255;
        c = (n != 0) ? (((a >> (8 - n)) & 1) == 1) : 0;
        lat = (n == 0) ? 1 : n;
      end
      3'd2: t = a ^ b;
      3'd3: t = a & b;
      3'd4: begin t = a - b; c = (a >= b); wr = 0; end
      3'd5: begin t = b; fl = 0; end
      3'd6: begin
        t = a >> n;
        c = (n != 0) ? (((a >> (n - 1)) & 1) == 1) : 0;
        lat = (n == 0) ? 1 : n;
      end
      default: begin t = a - b; c = (a >= b); end
    endcase
    res = 8'(t & 255);
  endtask

  // Reference model advanced on every rising edge from the driven inputs.
  always @(posedge clk) begin : model
    logic [7:0] r;
    bit c, wr, fl, load, acc, ready;
    logic [7:0] lOut;
    bit lC, lWr, lFl;
    int lat;
    if (Reset) begin
      mLeft = 0; mOutValid = 0; mOut = 8'h00; mWr = 0;
      mZ = 0; mC = 0; mN = 0; mAcc = 0;
    end else begin
      ready = (mLeft == 0) && (!mOutValid || OutReady);
      acc   = InValid && ready;
      load  = 0;
      lOut = 8'h00; lC = 0; lWr = 1; lFl = 1;
      if (mLeft > 0) begin
        mLeft--;
        if (mLeft == 0) begin
          load = 1; lOut = pRes; lC = pC; lWr = 1; lFl = 1;
        end
      end
      if (acc) begin
        calc(Op, int'(InA), int'(InB), r, c, wr, fl, lat);
        if (lat == 1) begin
          load = 1; lOut = r; lC = c; lWr = wr; lFl = fl;
        end else begin
          mLeft = lat - 1; pRes = r; pC = c;
        end
      end
      if (load) begin
        mOutValid = 1; mOut = lOut; mWr = lWr;
        if (lFl) begin
          mZ = (lOut == 0); mN = lOut[7]; mC = lC;
        end
      end else if (OutReady) begin
        mOutValid = 0;
      end
      mAcc = acc;
    end
  end

  // Every-cycle comparison of the DUT against the model, away from the clock edge.
  always @(negedge clk) begin
    if (cmpEn) begin
      chk("OutValid", OutValid, mOutValid);
      chk("InReady", InReady, (mLeft == 0) && (!mOutValid || OutReady));
      chk("Busy", Busy, mLeft > 0);
      chk("Out", Out, mOut);
      chk("OutWrEn", OutWrEn, mWr);
      chk("Zero", Zero, mZ);
      chk("Carry", Carry, mC);
      chk("Neg", Neg, mN);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    Op = op; InA = a; InB = b; InValid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (mAcc) break;
    end
    chk("issue_accept", mAcc, 1);
    InValid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    Reset = 1'b1; InValid = 1'b0; OutReady = 1'b1;
    Op = 3'd0; InA = 8'h00; InB = 8'h00;
    tick();
    tick();
    cmpEn = 1;
    chk("rst_InReady", InReady, 1);
    chk("rst_OutValid", OutValid, 0);
    chk("rst_Out", Out, 8'h00);
    chk("rst_Busy", Busy, 0);
    Reset = 1'b0;

    issue(3'd0, 8'hF0, 8'h20);
    chk("add_valid", OutValid, 1);
    chk("add_out", Out, 8'h10);
    chk("add_out_model", mOut, 8'h10);
    chk("add_carry", Carry, 1);
    chk("add_zero", Zero, 0);
    chk("add_neg", Neg, 0);
    chk("add_wren", OutWrEn, 1);

    issue(3'd4, 8'h03, 8'h07);
    chk("cmp_out", Out, 8'hFC);
    chk("cmp_out_model", mOut, 8'hFC);
    chk("cmp_wren", OutWrEn, 0);
    chk("cmp_carry", Carry, 0);
    chk("cmp_neg", Neg, 1);
    chk("cmp_zero", Zero, 0);
    issue(3'd5, 8'h00, 8'h55);
    chk("set_out", Out, 8'h55);
    chk("set_carry", Carry, 0);
    chk("set_neg", Neg, 1);
    chk("set_neg_model", mN, 1);

    issue(3'd1, 8'h81, 8'h03);
    chk("lsl_busy1", Busy, 1);
    chk("lsl_ready1", InReady, 0);
    tick();
    chk("lsl_busy2", Busy, 1);
    chk("lsl_ready2", InReady, 0);
    chk("lsl_valid2", OutValid, 0);
    tick();
    chk("lsl_valid3", OutValid, 1);
    chk("lsl_out", Out, 8'h08);
    chk("lsl_out_model", mOut, 8'h08);
    chk("lsl_carry", Carry, 0);
    issue(3'd6, 8'h81, 8'h01);
    chk("lsr_out", Out, 8'h40);
    chk("lsr_carry", Carry, 1);
    chk("lsr_carry_model", mC, 1);

    issue(3'd7, 8'h05, 8'h05);
    chk("sub_out", Out, 8'h00);
    chk("sub_zero", Zero, 1);
    chk("sub_carry", Carry, 1);
    issue(3'd2, 8'hAA, 8'hFF);
    chk("xor_out", Out, 8'h55);
    chk("xor_zero", Zero, 0);
    chk("xor_carry", Carry, 0);

    issue(3'd0, 8'h01, 8'h01);
    OutReady = 1'b0;
    Op = 3'd2; InA = 8'h0F; InB = 8'h03; InValid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_out", Out, 8'h02);
      chk("bp_valid", OutValid, 1);
      chk("bp_ready", InReady, 0);
      chk("bp_noacc", mAcc, 0);
    end
    OutReady = 1'b1;
    #1;
    chk("bp_release_ready", InReady, 1);
    tick();
    chk("bp_release_acc", mAcc, 1);
    chk("bp_release_out", Out, 8'h0C);
    InValid = 1'b0;

    issue(3'd0, 8'h80, 8'h80);
    chk("pre_rst_zero", Zero, 1);
    chk("pre_rst_carry", Carry, 1);
    issue(3'd1, 8'h01, 8'h07);
    chk("rs_busy", Busy, 1);
    tick();
    Reset = 1'b1;
    tick();
    chk("rs_valid", OutValid, 0);
    chk("rs_busy0", Busy, 0);
    chk("rs_zero", Zero, 0);
    chk("rs_carry", Carry, 0);
    chk("rs_neg", Neg, 0);
    chk("rs_ready", InReady, 1);
    Reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("rs_no_result", OutValid, 0);
    end

    for (int i = 0; i < 3000; i++) begin
      Reset    = ($urandom_range(0, 199) == 0);
      InValid  = ($urandom_range(0, 3) != 0);
      OutReady = ($urandom_range(0, 3) != 0);
      Op       = 3'($urandom);
      InA      = 8'($urandom);
      InB      = 8'($urandom);
      tick();
    end
    Reset = 1'b0; InValid = 1'b0; OutReady = 1'b1;
    tick();
    tick();
    cmpEn = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
